// File: rtl/twos_complement_generator.sv
// Single-stage registered two's-complement negation / pass-through unit
// with a valid qualifier, a zero flag and a most-negative overflow flag.
module twos_complement_generator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             negate_en,
    input  logic [WIDTH-1:0] input_number,
    output logic             out_valid,
    output logic [WIDTH-1:0] twos_complement_output,
    output logic             is_zero,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    // Carry-out of the increment is dropped by the WIDTH-bit result.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + ONE;
    endfunction

    logic [WIDTH-1:0] result_s;
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;
    logic             zero_d, zero_q;
    logic             ovf_d, ovf_q;

    // Next-state: capture a new result on in_valid, otherwise hold data and flags.
    always_comb begin
        result_s = negate_en ? negate(input_number) : input_number;
        valid_d  = 1'b0;
        data_d   = data_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        if (in_valid) begin
            valid_d = 1'b1;
            data_d  = result_s;
            zero_d  = (result_s == ZERO);
            ovf_d   = negate_en & (input_number == MOST_NEG);
        end else begin
            valid_d = 1'b0;
        end
    end

    // Output pipeline register; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= ZERO;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid              = valid_q;
    assign twos_complement_output = data_q;
    assign is_zero                = zero_q;
    assign overflow               = ovf_q;

endmodule

// File: tb/tb_twos_complement_generator.sv
// Self-checking bench: directed vector table, hold/reset sequences and
// randomized stimulus against an arithmetic reference model.
module tb_twos_complement_generator;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         negate_en;
    logic [W-1:0] input_number;
    logic         out_valid;
    logic [W-1:0] twos_complement_output;
    logic         is_zero;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic         m_valid;
    logic [W-1:0] m_out;
    logic         m_zero;
    logic         m_ovf;

    twos_complement_generator #(.WIDTH(W)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .in_valid               (in_valid),
        .negate_en              (negate_en),
        .input_number           (input_number),
        .out_valid              (out_valid),
        .twos_complement_output (twos_complement_output),
        .is_zero                (is_zero),
        .overflow               (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] in;
        logic         neg;
        logic [W-1:0] exp_out;
        logic         exp_zero;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_out   = '0;
        m_zero  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // Drive one cycle, advance the model, sample #1 after the edge.
    task automatic step(input logic v, input logic n, input logic [W-1:0] x);
        int r;
        @(negedge clk);
        in_valid     = v;
        negate_en    = n;
        input_number = x;
        @(posedge clk);
        if (v) begin
            r       = n ? ((2 ** W) - int'(x)) % (2 ** W) : int'(x);
            m_out   = W'(r);
            m_zero  = (r == 0);
            m_ovf   = n && (int'(x) == 2 ** (W - 1));
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, "_out"},   64'(twos_complement_output), 64'(m_out));
        chk({tag, "_zero"},  64'(is_zero), 64'(m_zero));
        chk({tag, "_ovf"},   64'(overflow), 64'(m_ovf));
    endtask

    initial begin
        vecs[0] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h0B, 1'b1, 8'hF5, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'hD5, 1'b1, 8'h2B, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h37, 1'b0, 8'h37, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 1'b0, 8'h80, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0};

        rst_n        = 1'b0;
        in_valid     = 1'b1;
        negate_en    = 1'b1;
        input_number = 8'h05;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // directed table, back-to-back cycles
        for (int i = 0; i < 8; i++) begin
            step(1'b1, vecs[i].neg, vecs[i].in);
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_out", i), 64'(twos_complement_output), 64'(vecs[i].exp_out));
            chk($sformatf("vec%0d_zero", i), 64'(is_zero), 64'(vecs[i].exp_zero));
            chk($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vecs[i].exp_ovf));
        end

        // hold: overflow result followed by three idle cycles
        step(1'b1, 1'b1, 8'h80);
        chk_model("pre_hold");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h12);
            chk("hold_valid", 64'(out_valid), 64'd0);
            chk("hold_out", 64'(twos_complement_output), 64'h80);
            chk("hold_zero", 64'(is_zero), 64'd0);
            chk("hold_ovf", 64'(overflow), 64'd1);
        end

        // asynchronous reset between edges mid-stream
        step(1'b1, 1'b1, 8'h80);
        step(1'b1, 1'b1, 8'h00);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out", 64'(twos_complement_output), 64'd0);
        chk("async_rst_zero", 64'(is_zero), 64'd0);
        chk("async_rst_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 8'h01);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_out", 64'(twos_complement_output), 64'hFF);
        chk_model("post_rst");

        // randomized stimulus with corner values mixed in
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] x;
            case ($urandom_range(0, 5))
                0:       x = 8'h80;
                1:       x = 8'h00;
                2:       x = 8'hFF;
                default: x = W'($urandom);
            endcase
            step(($urandom_range(0, 3) != 0), 1'($urandom), x);
            chk_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
